cnn_ecg: RTL and testbench

- Fixed-weight 1-D convolutional ECG beat classifier. It sits after the FIR filter stage.
- Takes one 32-sample segment of signed 16-bit filtered ECG samples.
- Runs a 3-tap convolution, extracts features (R peaks, RR spacing, ST level, negative excursion) and thresholds them.
- Produces an 8-bit one-hot-per-condition detection vector. One segment is processed per start, sequentially, one conv output per clock.

---
 rtl/cnn_ecg.sv | 151 +++++++++++++++
 tb/tb_cnn_ecg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cnn_ecg.sv
// rtl/cnn_ecg.sv - fixed-weight 1-D conv ECG beat classifier, one conv output per clock
`timescale 1ns/1ps
module cnn_ecg #(
  parameter int PEAK_TH = 40,
  parameter int R_HI    = 120,
  parameter int R_LO    = 30,
  parameter int RR_MIN  = 8,
  parameter int RR_MAX  = 20,
  parameter int PVC_NEG = -64,
  parameter int ST_HI   = 16,
  parameter int ST_LO   = -16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] ecg_in,
  output logic         busy,
  output logic         done,
  output logic [7:0]   class_out
);

  // thresholds resized to the width of the quantity they are compared against
  localparam logic signed [17:0] PEAK_W  = 18'(PEAK_TH);
  localparam logic signed [17:0] R_HI_W  = 18'(R_HI);
  localparam logic signed [17:0] R_LO_W  = 18'(R_LO);
  localparam logic signed [17:0] PVC_W   = 18'(PVC_NEG);
  localparam logic signed [5:0]  RRMIN_W = 6'(RR_MIN);
  localparam logic signed [5:0]  RRMAX_W = 6'(RR_MAX);
  localparam logic signed [20:0] ST_HI_W = 21'(ST_HI);
  localparam logic signed [20:0] ST_LO_W = 21'(ST_LO);

  typedef enum logic [1:0] {IDLE, CONV, CLASS} state_t;

  state_t state, state_nx;

  logic signed [15:0] x [32];
  logic [4:0]         idx, idx_p1, idx_p2;
  logic signed [17:0] x0, x1, x2, y, y1, y2, rmax, rmin;
  logic [2:0]         npk;
  logic [4:0]         p1, p2;
  logic signed [20:0] st_sum, st;
  logic signed [5:0]  rr;
  logic               peak, two_pk;
  logic [7:0]         flags;

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic: a segment always takes exactly 30 conv cycles then one classify cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (idx == 5'd29) state_nx = CLASS;
      CLASS:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // 3-tap [1 2 1] kernel at the current index plus the peak test on the previous output
  always_comb begin
    idx_p1 = idx + 5'd1;
    idx_p2 = idx + 5'd2;
    x0 = {{2{x[idx][15]}}, x[idx]};
    x1 = {{2{x[idx_p1][15]}}, x[idx_p1]};
    x2 = {{2{x[idx_p2][15]}}, x[idx_p2]};
    y  = x0 + (x1 <<< 1) + x2;
    peak = (idx >= 5'd2) && (y1 > y2) && (y1 >= y) && (y1 >= PEAK_W);
  end

  // threshold the accumulated features into the condition flags; Normal means nothing else fired
  always_comb begin
    flags  = 8'h00;
    two_pk = (npk >= 3'd2);
    rr     = $signed({1'b0, p2}) - $signed({1'b0, p1});
    st     = st_sum >>> 3;
    flags[1] = (rmin < PVC_W);
    flags[2] = two_pk && (rr < RRMIN_W);
    flags[3] = !two_pk || (rr > RRMAX_W);
    flags[4] = (st > ST_HI_W);
    flags[5] = (st < ST_LO_W);
    flags[6] = (rmax > R_HI_W);
    flags[7] = (rmax < R_LO_W);
    flags[0] = ~|flags[7:1];
  end

  // datapath: latch the segment, accumulate features during CONV, publish the result in CLASS
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) x[i] <= '0;
      idx       <= '0;
      y1        <= '0;
      y2        <= '0;
      rmax      <= '0;
      rmin      <= '0;
      npk       <= '0;
      p1        <= '0;
      p2        <= '0;
      st_sum    <= '0;
      done      <= 1'b0;
      class_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 32; i++) x[i] <= ecg_in[16*i +: 16];
            idx    <= '0;
            y1     <= '0;
            y2     <= '0;
            rmax   <= '0;
            rmin   <= '0;
            npk    <= '0;
            p1     <= '0;
            p2     <= '0;
            st_sum <= '0;
          end
        end
        CONV: begin
          idx <= idx_p1;
          y1  <= y;
          y2  <= y1;
          if (idx == 5'd0) begin
            rmax <= y;
            rmin <= y;
          end else begin
            if (y > rmax) rmax <= y;
            if (y < rmin) rmin <= y;
          end
          if (peak) begin
            if (npk == 3'd0) p1 <= idx - 5'd1;
            if (npk == 3'd1) p2 <= idx - 5'd1;
            if (npk != 3'd7) npk <= npk + 3'd1;
          end
          if (idx >= 5'd22) st_sum <= st_sum + {{3{y[17]}}, y};
        end
        CLASS: begin
          class_out <= flags;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_ecg.sv
// tb/tb_cnn_ecg.sv - table-driven scoreboard bench for cnn_ecg
`timescale 1ns/1ps
module tb_cnn_ecg;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [511:0] ecg_in;
  logic         busy, done;
  logic [7:0]   class_out;

  always #5 clk = ~clk;

  cnn_ecg dut (
    .clk(clk), .rst(rst), .start(start), .ecg_in(ecg_in),
    .busy(busy), .done(done), .class_out(class_out)
  );

  typedef struct {
    logic [511:0] seg;
    logic [7:0]   exp;
    string        name;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] sb[$];
  int         total = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] pack(input int v[32]);
    logic [511:0] r;
    for (int i = 0; i < 32; i++) r[16*i +: 16] = 16'(v[i]);
    return r;
  endfunction

  // scoreboard: every done pops the expected class pushed when that run was started
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", {31'b0, done}, 32'd0);
      else check("class_out", {24'b0, class_out}, {24'b0, sb.pop_front()});
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    if (!done) check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic run_seg(input logic [511:0] seg, input logic [7:0] exp, input string name);
    int cyc;
    ecg_in = seg;
    start  = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(cyc);
    check({name, "_latency"}, cyc, 32'd31);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int s1[32] = '{10,15,20,18,10,5,0,-5,-10,-8,0,5,10,12,15,20,
                   18,15,12,10,8,5,2,0,-2,-5,-8,-10,-5,0,5,10};
    int s2[32];
    int s3[32];
    int s4[32];
    int cyc, ndone;

    foreach (s2[i]) s2[i] = 2 * s1[i];
    foreach (s3[i]) s3[i] = 0;
    foreach (s4[i]) s4[i] = (i % 6 == 2) ? 100 : 0;
    vecs[0] = '{pack(s1), 8'h01, "normal"};
    vecs[1] = '{pack(s2), 8'h62, "doubled"};
    vecs[2] = '{pack(s3), 8'h88, "zero"};
    vecs[3] = '{pack(s4), 8'h54, "peaks"};

    rst = 1'b1; start = 1'b0; ecg_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_class", {24'b0, class_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) run_seg(vecs[v].seg, vecs[v].exp, vecs[v].name);

    // back-to-back: new start raised in the done cycle
    ecg_in = vecs[1].seg; start = 1'b1; sb.push_back(vecs[1].exp);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    ecg_in = vecs[2].seg; start = 1'b1; sb.push_back(vecs[2].exp);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_latency", cyc, 32'd31);
    @(negedge clk);

    // start held high through much of the run while ecg_in changes underneath
    ecg_in = vecs[3].seg; start = 1'b1; sb.push_back(vecs[3].exp);
    repeat (5) @(negedge clk);
    ecg_in = vecs[0].seg;
    repeat (15) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("held_start_done_count", ndone, 32'd1);

    // reset in the middle of a run: aborted, no done, outputs cleared
    ecg_in = vecs[1].seg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_class", {24'b0, class_out}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    run_seg(vecs[0].seg, vecs[0].exp, "after_abort");

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
